// File: rtl/conv_channel_acc.sv
// conv_channel_acc: multi-channel convolution window accumulator.
// Each accepted beat is one input channel. The beat's KERNEL*KERNEL taps are
// multiplied by their weights (stage 1) and summed (stage 2). The window sum
// is then added into a channel accumulator (stage 3). After CIN channels the
// result is held on out_data until the consumer takes it.
// Optional feature: define CONV_RELU_EN to clamp negative results to zero
// when the result is loaded into out_data.
module conv_channel_acc #(
  parameter int KERNEL = 3,
  parameter int N      = 4,
  parameter int M      = 4,
  parameter int E      = 4,
  parameter int CIN    = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clr,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [KERNEL*KERNEL*N-1:0]       data2conv,
  input  logic [KERNEL*KERNEL*M-1:0]       w,
  input  logic [N+M-1:0]                   bias,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [N+M+E+$clog2(CIN):0]       out_data
);

  localparam int TAPS = KERNEL * KERNEL;
  localparam int PW   = N + M;
  localparam int SW   = N + M + E;
  localparam int CE   = $clog2(CIN) + 1;
  localparam int ACCW = N + M + E + CE;
  localparam int CW   = (CIN > 1) ? $clog2(CIN) : 1;

  typedef enum logic [1:0] {ACC, DRAIN, OUT} state_t;

  state_t state_q, state_d;

  logic [CW-1:0]          cnt_q;
  logic                   accept;
  logic                   last_beat;

  logic signed [PW-1:0]   d_ext  [TAPS];
  logic signed [PW-1:0]   w_ext  [TAPS];
  logic signed [PW-1:0]   prod_c [TAPS];

  logic                   s1_valid, s1_first, s1_last;
  logic signed [PW-1:0]   s1_prod [TAPS];
  logic [PW-1:0]          s1_bias;

  logic signed [SW-1:0]   sum_c;
  logic                   s2_valid, s2_first, s2_last;
  logic signed [SW-1:0]   s2_sum;
  logic [PW-1:0]          s2_bias;

  logic signed [ACCW-1:0] acc_q;
  logic signed [ACCW-1:0] acc_base;
  logic signed [ACCW-1:0] acc_next;
  logic [ACCW-1:0]        result;
  logic                   load_out;

  assign in_ready  = (state_q == ACC) && !rst;
  assign out_valid = (state_q == OUT);
  assign accept    = in_valid && in_ready && !clr;
  assign last_beat = (cnt_q == CW'(CIN - 1));
  assign load_out  = (state_q == DRAIN) && s2_valid && s2_last && !clr;

  // Per-tap signed products of the incoming beat.
  always_comb begin
    for (int unsigned i = 0; i < TAPS; i++) begin
      d_ext[i]  = {{M{data2conv[i*N + N - 1]}}, data2conv[i*N +: N]};
      w_ext[i]  = {{N{w[i*M + M - 1]}}, w[i*M +: M]};
      prod_c[i] = d_ext[i] * w_ext[i];
    end
  end

  // Channel counter: counts accepted beats, wraps after the last channel.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= last_beat ? '0 : cnt_q + CW'(1);
    end
  end

  // Stage 1: register products with channel position and bias.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
    end
    s1_prod  <= prod_c;
    s1_first <= (cnt_q == '0);
    s1_last  <= last_beat;
    s1_bias  <= bias;
  end

  // Window sum of the stage-1 products, sign-extended to the sum width.
  always_comb begin
    sum_c = '0;
    for (int unsigned i = 0; i < TAPS; i++) begin
      sum_c = sum_c + {{E{s1_prod[i][PW-1]}}, s1_prod[i]};
    end
  end

  // Stage 2: register the window sum.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      s2_valid <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
    end
    s2_sum   <= sum_c;
    s2_first <= s1_first;
    s2_last  <= s1_last;
    s2_bias  <= s1_bias;
  end

  // Stage 3 arithmetic: the first channel restarts from the bias.
  always_comb begin
    acc_base = s2_first ? {{(ACCW-PW){s2_bias[PW-1]}}, s2_bias} : acc_q;
    acc_next = acc_base + {{CE{s2_sum[SW-1]}}, s2_sum};
`ifdef CONV_RELU_EN
    result   = acc_next[ACCW-1] ? '0 : acc_next;
`else
    result   = acc_next;
`endif
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc_q <= '0;
    end else if (s2_valid) begin
      acc_q <= acc_next;
    end
  end

  // Output register is loaded in the same edge as the final accumulation,
  // so the result appears together with out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
    end else if (load_out) begin
      out_data <= result;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACC;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACC:     if (accept && last_beat) state_d = DRAIN;
      DRAIN:   if (load_out)            state_d = OUT;
      OUT:     if (out_ready)           state_d = ACC;
      default:                          state_d = ACC;
    endcase
    if (clr) state_d = ACC;
  end

endmodule

// File: tb/tb_conv_channel_acc.sv
// Testbench for conv_channel_acc with default parameters.
// Each beat set is checked against an integer reference computed as
// bias(channel 0) + sum over channels and taps of data*weight.
module tb_conv_channel_acc;

  localparam int KERNEL = 3;
  localparam int N      = 4;
  localparam int M      = 4;
  localparam int E      = 4;
  localparam int CIN    = 4;
  localparam int TAPS   = KERNEL * KERNEL;
  localparam int DW     = TAPS * N;
  localparam int WW     = TAPS * M;
  localparam int BW     = N + M;
  localparam int AW     = N + M + E + $clog2(CIN) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] data2conv = '0;
  logic [WW-1:0] w = '0;
  logic [BW-1:0] bias = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [AW-1:0] out_data;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] bd [CIN];
  logic [WW-1:0] bw [CIN];
  logic [BW-1:0] bb [CIN];

  always #5 clk = ~clk;

  conv_channel_acc #(
    .KERNEL(KERNEL),
    .N(N),
    .M(M),
    .E(E),
    .CIN(CIN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .data2conv(data2conv),
    .w(w),
    .bias(bias),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_const(input int d, input int wt, input int b);
    for (int c = 0; c < CIN; c++) begin
      for (int i = 0; i < TAPS; i++) begin
        bd[c][i*N +: N] = N'(d);
        bw[c][i*M +: M] = M'(wt);
      end
      bb[c] = BW'(b);
    end
  endtask

  task automatic fill_rand();
    for (int c = 0; c < CIN; c++) begin
      for (int i = 0; i < TAPS; i++) begin
        bd[c][i*N +: N] = N'($urandom_range(0, (1 << N) - 1));
        bw[c][i*M +: M] = M'($urandom_range(0, (1 << M) - 1));
      end
      bb[c] = BW'($urandom_range(0, (1 << BW) - 1));
    end
  endtask

  // Reference: plain integer convolution sum over all channels.
  function automatic logic [AW-1:0] model_result();
    int s;
    logic [N-1:0] dv;
    logic [M-1:0] wv;
    s = int'($signed(bb[0]));
    for (int c = 0; c < CIN; c++) begin
      for (int i = 0; i < TAPS; i++) begin
        dv = bd[c][i*N +: N];
        wv = bw[c][i*M +: M];
        s += int'($signed(dv)) * int'($signed(wv));
      end
    end
`ifdef CONV_RELU_EN
    if (s < 0) s = 0;
`endif
    return s[AW-1:0];
  endfunction

  task automatic put_beat(input int c);
    data2conv = bd[c];
    w         = bw[c];
    bias      = bb[c];
    in_valid  = 1'b1;
    step();
    in_valid  = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic run_set(output logic [AW-1:0] got, output int lat);
    for (int c = 0; c < CIN; c++) put_beat(c);
    wait_out(lat);
    got = out_data;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (out_data !== '0) begin
      errors++; $display("FAIL reset_out_data: got %0d expected 0", out_data);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL release_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [AW-1:0] got;
    logic [AW-1:0] exp;
    int lat;
    // all ones -> 9 taps * 4 channels
    fill_const(1, 1, 0);
    run_set(got, lat);
    checks++;
    if (lat !== 2) begin
      errors++; $display("FAIL ones_latency: got %0d expected 2", lat);
    end
    checks++;
    if (got !== AW'(36)) begin
      errors++; $display("FAIL ones_data: got %0d expected 36", $signed(got));
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL out_in_ready: got %b expected 0", in_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL after_out: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
    end
    // negative result, bias only taken from channel 0
    fill_const(-8, 7, 5);
`ifdef CONV_RELU_EN
    exp = '0;
`else
    exp = AW'(-2011);
`endif
    run_set(got, lat);
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL neg_data: got %0d expected %0d", $signed(got), $signed(exp));
    end
    step();
    // largest magnitude
    fill_const(-8, -8, 127);
    run_set(got, lat);
    checks++;
    if (got !== AW'(2431)) begin
      errors++; $display("FAIL maxmag_data: got %0d expected 2431", $signed(got));
    end
    step();
  endtask

  task automatic test_random();
    logic [AW-1:0] got;
    logic [AW-1:0] exp;
    int lat;
    for (int k = 0; k < 10; k++) begin
      fill_rand();
      exp = model_result();
      run_set(got, lat);
      checks++;
      if (got !== exp || lat !== 2) begin
        errors++;
        $display("FAIL random_%0d: got %0d lat %0d expected %0d lat 2", k, $signed(got), lat, $signed(exp));
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] got;
    logic [AW-1:0] exp;
    int lat;
    out_ready = 1'b0;
    fill_rand();
    exp = model_result();
    run_set(got, lat);
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL bp_data: got %0d expected %0d", $signed(got), $signed(exp));
    end
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: got valid=%b data=%0d ready=%b expected valid=1 data=%0d ready=0",
                 k, out_valid, $signed(out_data), in_ready, $signed(exp));
      end
    end
    // handshake cycle overlaps the first beat of the next set
    fill_rand();
    exp = model_result();
    data2conv = bd[0];
    w         = bw[0];
    bias      = bb[0];
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release: got ready=%b valid=%b expected ready=1 valid=0", in_ready, out_valid);
    end
    run_set(got, lat);
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL overlap_data: got %0d expected %0d", $signed(got), $signed(exp));
    end
    step();
  endtask

  task automatic test_clr();
    logic [AW-1:0] got;
    int lat;
    int seen;
    fill_rand();
    put_beat(0);
    put_beat(1);
    clr       = 1'b1;
    data2conv = bd[2];
    w         = bw[2];
    bias      = bb[2];
    in_valid  = 1'b1;
    step();
    clr      = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL clr_in_ready: got %b expected 1", in_ready);
    end
    fill_const(1, 2, 0);
    run_set(got, lat);
    checks++;
    if (got !== AW'(72) || lat !== 2) begin
      errors++; $display("FAIL clr_data: got %0d lat %0d expected 72 lat 2", $signed(got), lat);
    end
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL clr_extra_out: got %0d expected 0", seen);
    end
  endtask

  task automatic test_rst_drain();
    logic [AW-1:0] got;
    int lat;
    int seen;
    fill_rand();
    for (int c = 0; c < CIN; c++) put_beat(c);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL drain_state: got ready=%b valid=%b expected ready=0 valid=0", in_ready, out_valid);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (out_valid) seen++;
      step();
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL rst_drain_out: got %0d expected 0", seen);
    end
    fill_const(1, 1, 0);
    run_set(got, lat);
    checks++;
    if (got !== AW'(36) || lat !== 2) begin
      errors++; $display("FAIL rst_drain_data: got %0d lat %0d expected 36 lat 2", $signed(got), lat);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_clr();
    test_rst_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_channel_acc.md
CONV_CHANNEL_ACC -- requirements
Module: conv_channel_acc

Interface
REQ-001 Parameter KERNEL, default 3, kernel side; a window is KERNEL*KERNEL taps.
REQ-002 Parameter N, default 4, signed data width per tap.
REQ-003 Parameter M, default 4, signed weight width per tap.
REQ-004 Parameter E, default 4, window-sum extension bits; E >= ceil(log2(KERNEL*KERNEL)).
REQ-005 Parameter CIN, default 4, input channels accumulated per output; CIN >= 1.
REQ-006 Localparams: CE = ceil(log2(CIN))+1; ACCW = N+M+E+CE.
REQ-007 clk  input  1  clock; all state changes on its rising edge.
REQ-008 rst  input  1  reset, synchronous, active-high.
REQ-009 clr  input  1  synchronous flush of the current accumulation.
REQ-010 in_valid  input  1  data2conv/w/bias valid.
REQ-011 in_ready  output  1  block can accept a channel beat.
REQ-012 data2conv  input  KERNEL*KERNEL*N  window taps; tap i at [i*N +: N].
REQ-013 w  input  KERNEL*KERNEL*M  weights; tap i at [i*M +: M].
REQ-014 bias  input  N+M  signed bias; sampled only on the channel-0 beat.
REQ-015 out_valid  output  1  out_data holds a finished result.
REQ-016 out_ready  input  1  consumer accepts out_data.
REQ-017 out_data  output  ACCW  signed result.

Function
REQ-018 A beat is accepted when in_valid && in_ready; each accepted beat is one input channel.
REQ-019 Stage 1 registers KERNEL*KERNEL signed products, each N+M bits, one cycle after acceptance.
REQ-020 Stage 2 registers the window sum, sign-extended to N+M+E bits, one cycle after stage 1.
REQ-021 Stage 3 adds the window sum, sign-extended to ACCW, into the accumulator.
- Channel 0: accumulator preloaded with sign-extended bias.
REQ-022 A channel counter (0..CIN-1) advances on each accepted beat and wraps to 0 after beat CIN-1.
REQ-023 FSM states ACC, DRAIN, OUT; reset state ACC.
REQ-024 ACC: in_ready=1; accepting beat CIN-1 moves to DRAIN.
REQ-025 DRAIN: in_ready=0; after the final window sum is accumulated, moves to OUT.
REQ-026 Latency: last beat accepted at cycle t gives out_valid=1 at cycle t+3.
REQ-027 OUT: in_ready=0, out_valid=1, out_data stable until out_valid && out_ready; then back to ACC with counter 0.
REQ-028 The out_ready=1 handshake cycle may coincide with the next beat's in_valid; that beat is accepted on the following cycle (in_ready rises after the OUT->ACC transition).
REQ-029 Arithmetic: all two's complement; no overflow is possible for ACCW as defined; no saturation.
REQ-030 clr=1: pipeline valids, counter, accumulator and out_valid cleared; FSM to ACC next cycle.
- clr overrides a simultaneous in_valid (beat dropped) and a pending output (result discarded).
REQ-031 CIN=1: every accepted beat produces one output.

Reset
REQ-032 On rst=1 at a rising edge: FSM=ACC, counter=0, pipeline valids=0, accumulator=0, out_valid=0, out_data=0.
REQ-033 in_ready=0 while rst=1, and 1 on the first cycle after release.
REQ-034 Reset mid-accumulation or in OUT discards all partial state; no output is produced from pre-reset beats.

Configuration
REQ-035 Macro CONV_RELU_EN: when defined, a negative final result is replaced by 0 at the OUT load.
- Accumulation itself is unaffected.
- When undefined, out_data is the raw signed result.

Verification
REQ-036 Defaults; 4 beats with all taps data=1, w=1, bias=0 -> out_valid 3 cycles after beat 4; out_data=36.
REQ-037 4 beats with data=-8, w=7, bias=5 -> out_data=-2011; with CONV_RELU_EN defined -> out_data=0.
REQ-038 4 beats with data=-8, w=-8, bias=127 -> out_data=2431 (max-magnitude, no overflow).
REQ-039 out_ready held 0 for 5 cycles in OUT -> out_valid=1, out_data unchanged, in_ready=0; then out_ready=1 -> ACC, in_ready=1 next cycle.
REQ-040 clr after 2 of 4 beats, with in_valid=1 in the clr cycle, then 4 fresh beats of data=1, w=2, bias=0 -> single output 72.
REQ-041 rst pulsed in DRAIN -> no out_valid; the following 4 beats of data=1, w=1, bias=0 -> 36.
